downcnt_rr_sched: RTL and testbench

- Round-robin scheduler that shares one loadable synchronous down counter between N_REQ requesters.
- Each requester asks for a countdown of its own start value; the block grants the counter to one requester at a time, loads the value, and counts to zero under a global tick enable.
- On terminal count it returns a one-cycle done pulse to the owner.
- Sits between requester logic and the shared T-flip-flop down counter in the counters library.

---
 rtl/downcnt_rr_sched_pkg.sv | 15 +
 rtl/tff_down_counter.sv | 37 +++
 rtl/downcnt_rr_sched.sv | 120 ++++++++++++
 tb/tb_downcnt_rr_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/downcnt_rr_sched_pkg.sv
// Shared definitions for the round-robin down-counter scheduler:
// FSM state encodings and default sizing.
package downcnt_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_PTR_W = 2;

endpackage

// File: rtl/tff_down_counter.sv
// WIDTH-bit synchronous down counter built as a bank of toggle flops,
// with parallel load and hold-at-zero (never wraps below 0).
module tff_down_counter
  import downcnt_rr_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d, t;
  logic             lower_zero;

  // Bit i toggles on a decrement when every lower bit is zero (borrow ripple).
  always_comb begin
    t          = '0;
    lower_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]       = dec_i && (q_q != '0) && lower_zero;
      lower_zero = lower_zero && !q_q[i];
    end
    q_d = load_i ? load_val_i : (q_q ^ t);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/downcnt_rr_sched.sv
// Round-robin scheduler sharing one loadable down counter among N_REQ
// requesters; grants one owner, counts to zero on en_i, pulses done_o.
module downcnt_rr_sched
  import downcnt_rr_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] load_val_i,
  input  logic                   en_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       cnt_o
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx, cand;
  logic             win_vld, owner_req, cnt_load, cnt_dec;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] lv [N_REQ];
  int               idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lv
    assign lv[k] = load_val_i[k*WIDTH +: WIDTH];
  end

  // Search upward from ptr+1 with wrap; iterating from the far end lets the
  // nearest requester overwrite earlier candidates.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = 0;
    cand    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx  = (int'(ptr_q) + off) % N_REQ;
      cand = PTR_W'(idx);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // The pointer always names the current owner while not IDLE.
  assign owner_req = req_i[ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_vld) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!owner_req)     state_d = ST_IDLE;
        else if (cnt == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Abort takes priority over terminal count; done_o mirrors the held grant.
  always_comb begin
    gnt_d    = gnt_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d[win_idx] = 1'b1;
          ptr_d          = win_idx;
          cnt_load       = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!owner_req)     gnt_d   = '0;
        else if (cnt == '0) done_d  = gnt_q;
        else                cnt_dec = en_i;
      end
      ST_DONE: gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

  tff_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (lv[win_idx]),
    .dec_i      (cnt_dec),
    .q_o        (cnt)
  );

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = (state_q != ST_IDLE);
  assign cnt_o  = cnt;

endmodule

// File: tb/tb_downcnt_rr_sched.sv
// Scoreboard bench for downcnt_rr_sched: stimulus queues expected grant/done
// events, a monitor pops and compares them as the DUT produces them.
module tb_downcnt_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] load_val;
  logic        en;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [2:0]  cnt;

  typedef struct {
    bit         is_done;
    logic [3:0] val;
    logic [2:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_done = 0;

  downcnt_rr_sched #(.N_REQ(4), .WIDTH(3), .PTR_W(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .load_val_i (load_val),
    .en_i       (en),
    .gnt_o      (gnt),
    .done_o     (done),
    .busy_o     (busy),
    .cnt_o      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input logic [3:0] v, input logic [2:0] c);
    ev_t e;
    e.is_done = 1'b0; e.val = v; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] v);
    ev_t e;
    e.is_done = 1'b1; e.val = v; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  task automatic set_lv(input int k, input logic [2:0] v);
    load_val[k*3 +: 3] = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (n_done < target && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("wait_done_in_budget", 32'(n_done >= target), 32'd1);
  endtask

  task automatic sb_pop(input bit is_done, input logic [3:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_unexpected: got %s %b, expected no event (t=%0t)",
               is_done ? "done" : "grant", val, $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 32'(is_done), 32'(e.is_done));
      chk(is_done ? "sb_done_val" : "sb_gnt_val", 32'(val), 32'(e.val));
      if (!is_done) chk("sb_gnt_cnt", 32'(cnt), 32'(e.cnt));
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  initial begin
    logic [3:0] prev_gnt;
    logic       prev_busy;
    prev_gnt  = '0;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("done_onehot0", 32'($onehot0(done)), 32'd1);
      if (gnt != '0 && prev_gnt == '0) begin
        chk("gnt_after_idle", 32'(prev_busy), 32'd0);
        sb_pop(1'b0, gnt);
      end
      if (done != '0) begin
        n_done++;
        sb_pop(1'b1, done);
        chk("done_cnt_zero", 32'(cnt), 32'd0);
        chk("done_gnt_held", 32'(gnt), 32'(done));
      end
      prev_gnt  = gnt;
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; en = 1'b0; load_val = '0;
    cycles(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    cycles(1);

    // Single request, load 3.
    set_lv(0, 3'd3);
    push_gnt(4'b0001, 3'd3);
    push_done(4'b0001);
    req = 4'b0001; en = 1'b1;
    cycles(1); chk("t1_cnt_e0", 32'(cnt), 32'd3);
    chk("t1_gnt_e0", 32'(gnt), 32'b0001);
    cycles(1); chk("t1_cnt_e1", 32'(cnt), 32'd2);
    cycles(1); chk("t1_cnt_e2", 32'(cnt), 32'd1);
    cycles(1); chk("t1_cnt_e3", 32'(cnt), 32'd0);
    chk("t1_done_e3", 32'(done), 32'd0);
    cycles(1); chk("t1_done_e4", 32'(done), 32'b0001);
    req = '0;
    cycles(1);
    chk("t1_gnt_e5", 32'(gnt), 32'd0);
    chk("t1_busy_e5", 32'(busy), 32'd0);
    chk("t1_done_e5", 32'(done), 32'd0);
    cycles(1);

    // Round-robin from a fresh pointer: 0,1,2,3,0.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_lv(k, 3'd1);
    for (int k = 0; k < 5; k++) begin
      push_gnt(4'b0001 << (k % 4), 3'd1);
      push_done(4'b0001 << (k % 4));
    end
    req = 4'b1111; en = 1'b1;
    wait_done(n_done + 5);
    req = '0;
    cycles(3);

    // Tick gating: pointer=0, requester 1 with load 2.
    set_lv(1, 3'd2);
    push_gnt(4'b0010, 3'd2);
    push_done(4'b0010);
    req = 4'b0010; en = 1'b1;
    cycles(1); chk("t3_cnt_e0", 32'(cnt), 32'd2); en = 1'b1;
    cycles(1); chk("t3_cnt_e1", 32'(cnt), 32'd1); en = 1'b0;
    cycles(1); chk("t3_cnt_e2", 32'(cnt), 32'd1); en = 1'b1;
    cycles(1); chk("t3_cnt_e3", 32'(cnt), 32'd0); en = 1'b0;
    cycles(1); chk("t3_cnt_e4", 32'(cnt), 32'd0);
    chk("t3_done_e4", 32'(done), 32'b0010);
    req = '0; en = 1'b1;
    cycles(2);

    // Zero load: DONE one edge after the grant.
    set_lv(2, 3'd0);
    push_gnt(4'b0100, 3'd0);
    push_done(4'b0100);
    req = 4'b0100;
    cycles(1);
    chk("t4_cnt_e0", 32'(cnt), 32'd0);
    chk("t4_done_e0", 32'(done), 32'd0);
    chk("t4_busy_e0", 32'(busy), 32'd1);
    cycles(1); chk("t4_done_e1", 32'(done), 32'b0100);
    req = '0;
    cycles(2);

    // Abort at cnt=2 of a load of 5; late load_val change ignored.
    set_lv(3, 3'd5);
    push_gnt(4'b1000, 3'd5);
    req = 4'b1000; en = 1'b1;
    cycles(1); chk("t5_cnt_e0", 32'(cnt), 32'd5);
    set_lv(3, 3'd7);
    cycles(1); chk("t5_cnt_e1", 32'(cnt), 32'd4);
    cycles(1); chk("t5_cnt_e2", 32'(cnt), 32'd3);
    cycles(1); chk("t5_cnt_e3", 32'(cnt), 32'd2);
    req = '0;
    cycles(1);
    chk("t5_abort_gnt", 32'(gnt), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd0);
    chk("t5_abort_cnt", 32'(cnt), 32'd2);
    cycles(3);
    chk("t5_cnt_hold", 32'(cnt), 32'd2);

    // Async reset mid-COUNT, then pointer restart and re-request order.
    set_lv(0, 3'd4);
    push_gnt(4'b0001, 3'd4);
    req = 4'b0001; en = 1'b1;
    cycles(1); chk("t6_cnt_e0", 32'(cnt), 32'd4);
    cycles(1); chk("t6_cnt_e1", 32'(cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_lv(0, 3'd1);
    set_lv(3, 3'd1);
    push_gnt(4'b0001, 3'd1);
    push_done(4'b0001);
    push_gnt(4'b1000, 3'd1);
    push_done(4'b1000);
    req = 4'b1001;
    wait_done(n_done + 2);
    req = '0;
    cycles(3);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
